// File: rtl/uart_baud_gen_frac.sv
// Fractional baud-rate generator: a down-counter sets the oversample period and a
// phase accumulator stretches selected periods by one cycle to resolve BAUD_FRAC.
module uart_baud_gen_frac #(
  parameter int CNT_WIDTH  = 13,
  parameter int FRAC_WIDTH = 3,
  parameter int OSR        = 16
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    EN,
  input  logic                    LOAD,
  input  logic                    RESTART,
  input  logic [CNT_WIDTH-1:0]    BAUD_VAL,
  input  logic [FRAC_WIDTH-1:0]   BAUD_FRAC,
  output logic                    OS_TICK,
  output logic                    BIT_TICK,
  output logic                    MID_TICK,
  output logic [$clog2(OSR)-1:0]  OS_PHASE
);

  localparam int OS_W = $clog2(OSR);

  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  b_q, b_d;
  logic [FRAC_WIDTH-1:0] f_q, f_d;
  logic [FRAC_WIDTH-1:0] acc_q, acc_d;
  logic                  stretch_q, stretch_d;
  logic [OS_W-1:0]       os_cnt_q, os_cnt_d;
  logic                  os_tick_q, os_tick_d;
  logic                  bit_tick_q, bit_tick_d;
  logic                  mid_tick_q, mid_tick_d;
  logic [FRAC_WIDTH:0]   frac_sum;
  logic                  last_os;

  always_comb begin
    cnt_d      = cnt_q;
    b_d        = b_q;
    f_d        = f_q;
    acc_d      = acc_q;
    stretch_d  = stretch_q;
    os_cnt_d   = os_cnt_q;
    os_tick_d  = 1'b0;
    bit_tick_d = 1'b0;
    mid_tick_d = 1'b0;
    frac_sum   = {1'b0, acc_q} + {1'b0, f_q};
    last_os    = (os_cnt_q == OS_W'(OSR - 1));

    if (LOAD) begin
      b_d       = BAUD_VAL;
      f_d       = BAUD_FRAC;
      cnt_d     = BAUD_VAL;
      acc_d     = '0;
      stretch_d = 1'b0;
      os_cnt_d  = '0;
    end else if (RESTART) begin
      cnt_d     = b_q;
      acc_d     = '0;
      stretch_d = 1'b0;
      os_cnt_d  = '0;
    end else if (EN) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_WIDTH'(1);
      end else if (stretch_q) begin
        // Inserted cycle: the accumulator overflowed on the previous tick.
        stretch_d = 1'b0;
      end else begin
        os_tick_d  = 1'b1;
        cnt_d      = b_q;
        acc_d      = frac_sum[FRAC_WIDTH-1:0];
        stretch_d  = frac_sum[FRAC_WIDTH];
        bit_tick_d = last_os;
        mid_tick_d = (os_cnt_q == OS_W'(OSR / 2 - 1));
        os_cnt_d   = last_os ? '0 : os_cnt_q + OS_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q      <= '0;
      b_q        <= '0;
      f_q        <= '0;
      acc_q      <= '0;
      stretch_q  <= 1'b0;
      os_cnt_q   <= '0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
      mid_tick_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      b_q        <= b_d;
      f_q        <= f_d;
      acc_q      <= acc_d;
      stretch_q  <= stretch_d;
      os_cnt_q   <= os_cnt_d;
      os_tick_q  <= os_tick_d;
      bit_tick_q <= bit_tick_d;
      mid_tick_q <= mid_tick_d;
    end
  end

  assign OS_TICK  = os_tick_q;
  assign BIT_TICK = bit_tick_q;
  assign MID_TICK = mid_tick_q;
  assign OS_PHASE = os_cnt_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Directed bench for uart_baud_gen_frac: a per-cycle vector table followed by
// hand-written multi-cycle sequences for periods, re-phasing, gating and reset.
module tb_uart_baud_gen_frac;

  localparam int CW  = 13;
  localparam int FW  = 3;
  localparam int OSR = 16;
  localparam int OW  = 4;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          EN;
  logic          LOAD;
  logic          RESTART;
  logic [CW-1:0] BAUD_VAL;
  logic [FW-1:0] BAUD_FRAC;
  logic          OS_TICK;
  logic          BIT_TICK;
  logic          MID_TICK;
  logic [OW-1:0] OS_PHASE;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  uart_baud_gen_frac #(.CNT_WIDTH(CW), .FRAC_WIDTH(FW), .OSR(OSR)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .EN(EN), .LOAD(LOAD), .RESTART(RESTART),
    .BAUD_VAL(BAUD_VAL), .BAUD_FRAC(BAUD_FRAC), .OS_TICK(OS_TICK),
    .BIT_TICK(BIT_TICK), .MID_TICK(MID_TICK), .OS_PHASE(OS_PHASE)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  typedef struct {
    logic          load;
    logic          restart;
    logic          en;
    logic [CW-1:0] bv;
    logic [FW-1:0] bf;
    logic          os;
    logic          bt;
    logic          mt;
    logic [OW-1:0] ph;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(input logic ld, input logic rs, input logic en,
                              input int bv, input int bf, input logic os,
                              input logic bt, input logic mt, input int ph);
    vec_t v;
    v.load = ld; v.restart = rs; v.en = en;
    v.bv = CW'(bv); v.bf = FW'(bf);
    v.os = os; v.bt = bt; v.mt = mt; v.ph = OW'(ph);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input int b, input int f);
    LOAD      = 1'b1;
    RESTART   = 1'b0;
    EN        = 1'b1;
    BAUD_VAL  = CW'(b);
    BAUD_FRAC = FW'(f);
    step();
    LOAD = 1'b0;
  endtask

  task automatic wait_os(input int limit, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!OS_TICK && cyc < limit);
    if (!OS_TICK) begin
      total++;
      bad++;
      $display("FAIL wait_os: no OS_TICK within %0d cycles", limit);
    end
  endtask

  initial begin
    int c;
    int sum;
    logic [31:0] e;

    // load, restart, en, bv, bf | os, bit, mid, phase
    vecs[0]  = mk(1, 0, 1, 2, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 1, 2, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 1, 2, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 1, 2, 0, 1, 0, 0, 1);
    vecs[4]  = mk(0, 0, 1, 2, 0, 0, 0, 0, 1);
    vecs[5]  = mk(0, 0, 0, 2, 0, 0, 0, 0, 1);
    vecs[6]  = mk(0, 0, 1, 2, 0, 0, 0, 0, 1);
    vecs[7]  = mk(0, 0, 1, 2, 0, 1, 0, 0, 2);
    vecs[8]  = mk(1, 0, 1, 0, 4, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 1, 0, 4, 1, 0, 0, 1);
    vecs[10] = mk(0, 0, 1, 0, 4, 1, 0, 0, 2);
    vecs[11] = mk(0, 0, 1, 0, 4, 0, 0, 0, 2);
    vecs[12] = mk(0, 0, 1, 0, 4, 1, 0, 0, 3);
    vecs[13] = mk(0, 0, 1, 0, 4, 1, 0, 0, 4);
    vecs[14] = mk(0, 0, 1, 0, 4, 0, 0, 0, 4);
    vecs[15] = mk(0, 1, 1, 0, 4, 0, 0, 0, 0);
    vecs[16] = mk(0, 0, 1, 5, 4, 1, 0, 0, 1);
    vecs[17] = mk(0, 0, 1, 5, 4, 1, 0, 0, 2);
    vecs[18] = mk(1, 1, 0, 1, 0, 0, 0, 0, 0);
    vecs[19] = mk(0, 0, 1, 1, 0, 0, 0, 0, 0);
    vecs[20] = mk(0, 0, 1, 1, 0, 1, 0, 0, 1);
    vecs[21] = mk(0, 0, 1, 1, 0, 0, 0, 0, 1);
    vecs[22] = mk(0, 0, 1, 1, 0, 1, 0, 0, 2);

    RESET_N = 1'b0; EN = 1'b0; LOAD = 1'b0; RESTART = 1'b0;
    BAUD_VAL = '0; BAUD_FRAC = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset os", 32'(OS_TICK), 0);
    check("reset bit", 32'(BIT_TICK), 0);
    check("reset mid", 32'(MID_TICK), 0);
    check("reset phase", 32'(OS_PHASE), 0);
    RESET_N = 1'b1;

    for (int i = 0; i < 23; i++) begin
      LOAD = vecs[i].load; RESTART = vecs[i].restart; EN = vecs[i].en;
      BAUD_VAL = vecs[i].bv; BAUD_FRAC = vecs[i].bf;
      step();
      check($sformatf("vec%0d os", i), 32'(OS_TICK), 32'(vecs[i].os));
      check($sformatf("vec%0d bit", i), 32'(BIT_TICK), 32'(vecs[i].bt));
      check($sformatf("vec%0d mid", i), 32'(MID_TICK), 32'(vecs[i].mt));
      check($sformatf("vec%0d phase", i), 32'(OS_PHASE), 32'(vecs[i].ph));
    end
    LOAD = 1'b0; RESTART = 1'b0;

    // B=3 F=0: period 4, MID on 8th tick, BIT on every 16th tick
    do_load(3, 0);
    for (int n = 1; n <= 32; n++) begin
      wait_os(20, c);
      check($sformatf("b3 period%0d", n), c, 4);
      check($sformatf("b3 bit%0d", n), 32'(BIT_TICK), 32'(n % 16 == 0));
      check($sformatf("b3 mid%0d", n), 32'(MID_TICK), 32'(n % 16 == 8));
      check($sformatf("b3 phase%0d", n), 32'(OS_PHASE), n % 16);
    end

    // B=3 F=4: alternating 4/5 after the first tick, 16 periods = 72 cycles
    do_load(3, 4);
    wait_os(20, c);
    check("f4 first", c, 4);
    for (int j = 1; j <= 16; j++) exp_q.push_back((j % 2 == 1) ? 4 : 5);
    sum = 0;
    for (int j = 1; j <= 16; j++) begin
      wait_os(20, c);
      e = exp_q.pop_front();
      sum += c;
      check($sformatf("f4 period%0d", j), c, e);
    end
    check("f4 span", sum, 72);

    // B=0 F=0: continuous ticks
    do_load(0, 0);
    for (int j = 0; j < 20; j++) begin
      step();
      check($sformatf("b0 cont%0d", j), 32'(OS_TICK), 1);
    end

    // B=0 F=7: accumulator runs 7,6,5..0 so one single-cycle period per 8 ticks
    do_load(0, 7);
    wait_os(20, c);
    check("f7 first", c, 1);
    for (int j = 1; j <= 16; j++) exp_q.push_back(((j - 1) % 8 == 0) ? 1 : 2);
    sum = 0;
    for (int j = 1; j <= 16; j++) begin
      wait_os(20, c);
      e = exp_q.pop_front();
      sum += c;
      check($sformatf("f7 period%0d", j), c, e);
    end
    check("f7 span", sum, 30);

    // RESTART mid-bit at phase 9 with B=5
    do_load(5, 0);
    for (int n = 1; n <= 9; n++) wait_os(20, c);
    check("rs phase before", 32'(OS_PHASE), 9);
    step();
    step();
    RESTART = 1'b1;
    step();
    RESTART = 1'b0;
    check("rs phase after", 32'(OS_PHASE), 0);
    check("rs os after", 32'(OS_TICK), 0);
    wait_os(20, c);
    check("rs first period", c, 6);
    check("rs first phase", 32'(OS_PHASE), 1);
    check("rs first bit", 32'(BIT_TICK), 0);
    for (int n = 2; n <= 16; n++) begin
      wait_os(20, c);
      check($sformatf("rs period%0d", n), c, 6);
      check($sformatf("rs bit%0d", n), 32'(BIT_TICK), 32'(n == 16));
    end

    // EN gap with cnt=2 and acc=4 held across the gap
    do_load(5, 4);
    wait_os(20, c);
    check("gap first", c, 6);
    step(); step(); step();
    EN = 1'b0;
    for (int j = 0; j < 10; j++) begin
      step();
      check($sformatf("gap os%0d", j), 32'(OS_TICK), 0);
    end
    check("gap phase held", 32'(OS_PHASE), 1);
    EN = 1'b1;
    wait_os(20, c);
    check("gap resume", c, 3);
    check("gap phase next", 32'(OS_PHASE), 2);
    wait_os(20, c);
    check("gap acc kept", c, 7);

    // largest divisor: counter must not wrap
    do_load((1 << CW) - 1, 0);
    wait_os(9000, c);
    check("bmax period", c, 1 << CW);

    // asynchronous reset while cnt=1, stretch=1
    do_load(2, 4);
    wait_os(20, c);
    wait_os(20, c);
    check("ar period2", c, 3);
    step();
    #2;
    RESET_N = 1'b0;
    #1;
    check("ar os", 32'(OS_TICK), 0);
    check("ar bit", 32'(BIT_TICK), 0);
    check("ar mid", 32'(MID_TICK), 0);
    check("ar phase", 32'(OS_PHASE), 0);
    #10;
    EN = 1'b1; LOAD = 1'b0; RESTART = 1'b0;
    RESET_N = 1'b1;
    step();
    check("ar post os1", 32'(OS_TICK), 1);
    check("ar post ph1", 32'(OS_PHASE), 1);
    step();
    check("ar post os2", 32'(OS_TICK), 1);
    check("ar post ph2", 32'(OS_PHASE), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
